// File: rtl/p_mul_seq.sv
// Iterative packed multiplier: per-lane shift-and-add over a 32-bit datapath,
// with every step's lane addition performed by the packed add/sub block below.

// Packed add/sub: independent lanes; c_en=0 turns each lane into a bitwise XOR.
module p_addsub (
    input  logic [31:0] lhs,
    input  logic [31:0] rhs,
    input  logic [4:0]  pw,
    input  logic        sub,
    input  logic        cin,
    input  logic        c_en,
    output logic [31:0] result,
    output logic [31:0] cout
);
    logic [4:0] w_m1;
    logic       carry;
    logic       r_bit;
    logic       gen;

    always_comb begin
        if      (pw[0]) w_m1 = 5'd31;
        else if (pw[1]) w_m1 = 5'd15;
        else if (pw[2]) w_m1 = 5'd7;
        else if (pw[3]) w_m1 = 5'd3;
        else if (pw[4]) w_m1 = 5'd1;
        else            w_m1 = 5'd31;
    end

    // Carry chain restarts at every lane boundary, so lanes never interact.
    always_comb begin
        carry  = cin | sub;
        r_bit  = 1'b0;
        gen    = 1'b0;
        result = '0;
        cout   = '0;
        for (int i = 0; i < 32; i++) begin
            if ((5'(i) & w_m1) == 5'd0) carry = cin | sub;
            r_bit     = rhs[i] ^ sub;
            result[i] = lhs[i] ^ r_bit ^ carry;
            gen       = (lhs[i] & r_bit) | (carry & (lhs[i] ^ r_bit));
            cout[i]   = c_en & gen;
            carry     = c_en & gen;
        end
    end
endmodule

module p_mul_seq (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        valid,
    input  logic [31:0] crs1,
    input  logic [31:0] crs2,
    input  logic [4:0]  pw,
    input  logic        high,
    input  logic        clmul,
    output logic        ready,
    output logic [31:0] result
);
    // Handshake: valid is held with stable operands until the one-cycle
    // ready pulse; dropping valid during RUN aborts the operation silently.
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] acc_hi;
    logic [31:0] acc_lo;
    logic [4:0]  counter;
    logic [4:0]  pw_q;
    logic [4:0]  w_m1_q;
    logic        high_q;
    logic        clmul_q;

    logic [4:0]  pw_dec;
    logic [4:0]  w_m1_dec;
    logic [31:0] lane_start;
    logic [31:0] lane_msb;
    logic [31:0] addend;
    logic [31:0] add_sum;
    logic [31:0] add_cout;
    logic [31:0] sum_sr;
    logic [31:0] lo_sr;
    logic [31:0] next_hi;
    logic [31:0] next_lo;
    logic        b_bit;
    logic        s0;

    always_comb begin
        if      (pw[0]) begin pw_dec = 5'b00001; w_m1_dec = 5'd31; end
        else if (pw[1]) begin pw_dec = 5'b00010; w_m1_dec = 5'd15; end
        else if (pw[2]) begin pw_dec = 5'b00100; w_m1_dec = 5'd7;  end
        else if (pw[3]) begin pw_dec = 5'b01000; w_m1_dec = 5'd3;  end
        else if (pw[4]) begin pw_dec = 5'b10000; w_m1_dec = 5'd1;  end
        else            begin pw_dec = 5'b00001; w_m1_dec = 5'd31; end
    end

    always_comb begin
        lane_start = '0;
        for (int i = 0; i < 32; i++) begin
            lane_start[i] = ((5'(i) & w_m1_q) == 5'd0);
        end
    end

    assign lane_msb = {1'b1, lane_start[31:1]};
    assign sum_sr   = {1'b0, add_sum[31:1]};
    assign lo_sr    = {1'b0, acc_lo[31:1]};

    // Multiplier bit for each lane is the LSB of that lane in acc_lo.
    always_comb begin
        b_bit  = 1'b0;
        addend = '0;
        for (int i = 0; i < 32; i++) begin
            if (lane_start[i]) b_bit = acc_lo[i];
            addend[i] = crs1[i] & b_bit;
        end
    end

    p_addsub u_addsub (
        .lhs    (acc_hi),
        .rhs    (addend),
        .pw     (pw_q),
        .sub    (1'b0),
        .cin    (1'b0),
        .c_en   (~clmul_q),
        .result (add_sum),
        .cout   (add_cout)
    );

    // Shift {carry, sum} right into acc_hi; sum LSB enters the top of acc_lo.
    always_comb begin
        s0      = 1'b0;
        next_hi = '0;
        next_lo = '0;
        for (int i = 0; i < 32; i++) begin
            if (lane_start[i]) s0 = add_sum[i];
            if (lane_msb[i]) begin
                next_hi[i] = add_cout[i] & ~clmul_q;
                next_lo[i] = s0;
            end else begin
                next_hi[i] = sum_sr[i];
                next_lo[i] = lo_sr[i];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        case (state)
            IDLE: if (valid) state_nxt = RUN;
            RUN: begin
                if (!valid)                  state_nxt = IDLE;
                else if (counter == w_m1_q)  state_nxt = DONE;
            end
            DONE: begin
                ready     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign result = ready ? (high_q ? acc_hi : acc_lo) : 32'd0;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state   <= IDLE;
            acc_hi  <= '0;
            acc_lo  <= '0;
            counter <= '0;
            pw_q    <= 5'b00001;
            w_m1_q  <= 5'd31;
            high_q  <= 1'b0;
            clmul_q <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (valid) begin
                        acc_hi  <= '0;
                        acc_lo  <= crs2;
                        counter <= '0;
                        pw_q    <= pw_dec;
                        w_m1_q  <= w_m1_dec;
                        high_q  <= high;
                        clmul_q <= clmul;
                    end
                end
                RUN: begin
                    if (!valid) begin
                        acc_hi  <= '0;
                        acc_lo  <= '0;
                        counter <= '0;
                    end else begin
                        acc_hi  <= next_hi;
                        acc_lo  <= next_lo;
                        counter <= counter + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
